// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and helpers for the 4x4 keypad scanner:
//               FSM state encoding, enter-key codes and the row/column
//               to key-code map.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } keypad_state_e;

  // '*' selects operand 2, '#' selects operand 1 in the entry stage
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Physical position to key code
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = 4'd10;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = 4'd11;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = 4'd12;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = 4'd13;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
// Module      : keypad_sync
// Description : 4-bit two-flop synchronizer for the asynchronous keypad rows.
//               Resets to all-ones (rows idle high, i.e. no key).
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_async,
  output logic [3:0] o_sync
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Two register stages before the rows are used by any logic
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 4'hF;
      r_sync <= 4'hF;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan
// Description : 4x4 matrix keypad scanner and debouncer. Drives one column
//               low at a time, samples the synchronized rows once per column
//               period, rejects bounce and multi-key ghosting and delivers
//               one key code plus a one-cycle strobe per accepted press.
//               Optional feature macro: KEYPAD_AUTOREPEAT_EN (held-key
//               auto-repeat strobes every REPEAT_SAMPLES samples).
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV         = 1000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int REPEAT_SAMPLES   = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [3:0]  key,
  output logic [31:0] number,
  output logic [1:0]  pressed
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);

  localparam logic [1:0] S_SCAN     = 2'(ST_SCAN);
  localparam logic [1:0] S_DEBOUNCE = 2'(ST_DEBOUNCE);
  localparam logic [1:0] S_HELD     = 2'(ST_HELD);

  // Elaboration-time guard on the legal parameter ranges
  if (SCAN_DIV < 4 || DEBOUNCE_SAMPLES < 1 || REPEAT_SAMPLES < 1) begin : g_bad_param
    $error("keypad_scan: illegal parameter value");
  end

  logic [3:0]    w_row_sync;
  logic [3:0]    w_row_low;
  logic          w_single;
  logic [1:0]    w_row_idx;
  logic [3:0]    w_code;
  logic          w_tick;

  logic [DW-1:0] r_div;
  logic [1:0]    r_col;
  logic [1:0]    r_state;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_match;
  logic [CW-1:0] r_release;
  logic [3:0]    r_key;
  logic          r_strobe;
  logic          r_down;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SAMPLES + 1);
  logic [RW-1:0] r_repeat;
`endif

  keypad_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (row_n),
    .o_sync  (w_row_sync)
  );

  assign w_row_low = ~w_row_sync;
  // Exactly one row low; two or more low is a ghost and counts as no key
  assign w_single  = (w_row_low != 4'd0) && ((w_row_low & (w_row_low - 4'd1)) == 4'd0);
  assign w_code    = keymap(w_row_idx, r_col);
  assign w_tick    = (r_div == DW'(SCAN_DIV - 1));

  // Index of the low row (only meaningful when w_single)
  always_comb begin
    w_row_idx = 2'd0;
    if (w_row_low[3])      w_row_idx = 2'd3;
    else if (w_row_low[2]) w_row_idx = 2'd2;
    else if (w_row_low[1]) w_row_idx = 2'd1;
  end

  // Free-running sample divider, never stalls in any state
  always_ff @(posedge clk) begin
    if (rst) r_div <= '0;
    else     r_div <= w_tick ? '0 : r_div + 1'b1;
  end

  // Scan / debounce / held state machine, evaluated once per sample tick
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= 2'd0;
      r_state   <= S_SCAN;
      r_cand    <= 4'd0;
      r_match   <= '0;
      r_release <= '0;
      r_key     <= 4'd0;
      r_strobe  <= 1'b0;
      r_down    <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_repeat  <= '0;
`endif
    end else begin
      r_strobe <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (w_single) begin
              r_cand  <= w_code;
              r_match <= CW'(1);
              if (DEBOUNCE_SAMPLES == 1) begin
                r_key     <= w_code;
                r_strobe  <= 1'b1;
                r_down    <= 1'b1;
                r_release <= '0;
                r_state   <= S_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                r_repeat  <= '0;
`endif
              end else begin
                r_state <= S_DEBOUNCE;
              end
            end else begin
              r_col <= r_col + 2'd1;
            end
          end
          S_DEBOUNCE: begin
            if (w_single && (w_code == r_cand)) begin
              if (r_match + 1'b1 == CW'(DEBOUNCE_SAMPLES)) begin
                r_key     <= r_cand;
                r_strobe  <= 1'b1;
                r_down    <= 1'b1;
                r_release <= '0;
                r_state   <= S_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                r_repeat  <= '0;
`endif
              end else begin
                r_match <= r_match + 1'b1;
              end
            end else begin
              r_state <= S_SCAN;
              r_col   <= r_col + 2'd1;
            end
          end
          S_HELD: begin
            if (w_single) begin
              // Any key in this column, even a different one, keeps the hold alive
              r_release <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              if (r_repeat + 1'b1 == RW'(REPEAT_SAMPLES)) begin
                r_strobe <= 1'b1;
                r_repeat <= '0;
              end else begin
                r_repeat <= r_repeat + 1'b1;
              end
`endif
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
              r_repeat <= '0;
`endif
              if (r_release + 1'b1 == CW'(DEBOUNCE_SAMPLES)) begin
                r_release <= '0;
                r_down    <= 1'b0;
                r_state   <= S_SCAN;
                r_col     <= r_col + 2'd1;
              end else begin
                r_release <= r_release + 1'b1;
              end
            end
          end
          default: r_state <= S_SCAN;
        endcase
      end
    end
  end

  assign col_n   = ~(4'b0001 << r_col);
  assign key     = r_key;
  assign number  = {28'd0, r_key};
  assign pressed = {r_strobe, r_down};

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan
// Description : Directed self-checking bench for keypad_scan with a
//               behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE_SAMPLES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key;
  logic [31:0] number;
  logic [1:0]  pressed;

  // Closed switches, bit index = 4*row + col
  logic [15:0] kmask;

  int n_vec = 0;
  int n_err = 0;
  int n_rise = 0;
  int n_hi = 0;
  logic        p1_prev = 1'b0;
  logic [31:0] strobe_num = 32'hFFFF_FFFF;

  keypad_scan #(
    .SCAN_DIV         (4),
    .DEBOUNCE_SAMPLES (3),
    .REPEAT_SAMPLES   (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row_n   (row_n),
    .col_n   (col_n),
    .key     (key),
    .number  (number),
    .pressed (pressed)
  );

  always #5 clk = ~clk;

  // Key matrix: a closed switch pulls its row low while its column is driven
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (kmask[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // Strobe monitor: counts rising edges and high cycles, records number at strobe
  always @(negedge clk) begin
    if (pressed[1]) begin
      n_hi <= n_hi + 1;
      strobe_num <= number;
      if (!p1_prev) n_rise <= n_rise + 1;
    end
    p1_prev <= pressed[1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] v);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (col_n === v) found = 1'b1;
      else wait_cyc(1);
    end
    chk("wait_col", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_strobe(input int n);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (n_rise >= n) found = 1'b1;
      else wait_cyc(1);
    end
    chk("wait_strobe", {31'd0, found}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seen;
    kmask = 16'd0;
    rst   = 1'b1;
    wait_cyc(3);
    chk("rst_col_n",   {28'd0, col_n}, 32'hE);
    chk("rst_key",     {28'd0, key},   32'd0);
    chk("rst_number",  number,         32'd0);
    chk("rst_pressed", {30'd0, pressed}, 32'd0);
    rst = 1'b0;

    // Clean press of '6' (row 1, col 2)
    kmask[4*1+2] = 1'b1;
    wait_cyc(80);
    chk("clean_rises",   n_rise, 32'd1);
    chk("clean_width",   n_hi,   32'd1);
    chk("clean_number",  number, 32'd6);
    chk("clean_key",     {28'd0, key}, 32'd6);
    chk("clean_strobe_number", strobe_num, 32'd6);
    chk("clean_down",    {31'd0, pressed[0]}, 32'd1);
    kmask[4*1+2] = 1'b0;
    wait_cyc(8);
    chk("release_early_down", {31'd0, pressed[0]}, 32'd1);
    wait_cyc(12);
    chk("release_down",  {31'd0, pressed[0]}, 32'd0);
    chk("release_hold_number", number, 32'd6);
    chk("release_rises", n_rise, 32'd1);

    // Bounce on '1' (row 0, col 0): alternating samples never qualify
    for (int i = 0; i < 6; i++) begin
      kmask[0] = 1'b1; wait_cyc(4);
      kmask[0] = 1'b0; wait_cyc(4);
    end
    chk("bounce_no_strobe", n_rise, 32'd1);
    kmask[0] = 1'b1;
    wait_cyc(60);
    chk("bounce_rises",  n_rise, 32'd2);
    chk("bounce_width",  n_hi,   32'd2);
    chk("bounce_number", number, 32'd1);
    chk("bounce_strobe_number", strobe_num, 32'd1);
    kmask[0] = 1'b0;
    wait_cyc(24);
    chk("bounce_release", {31'd0, pressed[0]}, 32'd0);

    // Ghost: rows 0 and 2 on column 1 together
    kmask[4*0+1] = 1'b1;
    kmask[4*2+1] = 1'b1;
    wait_cyc(40);
    seen = 4'd0;
    for (int i = 0; i < 20; i++) begin
      seen = seen | ~col_n;
      wait_cyc(1);
    end
    chk("ghost_cols_cycle", {28'd0, seen}, 32'hF);
    chk("ghost_no_strobe",  n_rise, 32'd2);
    chk("ghost_pressed",    {30'd0, pressed}, 32'd0);
    chk("ghost_hold_number", number, 32'd1);
    kmask = 16'd0;
    wait_cyc(8);

    // Enter keys: '#' then '*'
    kmask[4*3+2] = 1'b1;
    wait_cyc(60);
    chk("hash_number", number, 32'd15);
    chk("hash_rises",  n_rise, 32'd3);
    kmask[4*3+2] = 1'b0;
    wait_cyc(24);
    kmask[4*3+0] = 1'b1;
    wait_cyc(60);
    chk("star_number", number, 32'd14);
    chk("star_strobe_number", strobe_num, 32'd14);
    chk("star_rises",  n_rise, 32'd4);
    kmask[4*3+0] = 1'b0;
    wait_cyc(24);
    chk("star_release", {31'd0, pressed[0]}, 32'd0);

    // Reset while debouncing '5' (row 1, col 1): one match taken, two pending
    wait_col(4'b1110);
    wait_col(4'b1101);
    kmask[4*1+1] = 1'b1;
    wait_cyc(6);
    rst = 1'b1;
    kmask[4*1+1] = 1'b0;
    wait_cyc(1);
    rst = 1'b0;
    chk("rst_deb_col_n",   {28'd0, col_n},   32'hE);
    chk("rst_deb_pressed", {30'd0, pressed}, 32'd0);
    chk("rst_deb_number",  number,           32'd0);
    wait_cyc(40);
    chk("rst_deb_no_strobe", n_rise, 32'd4);

    // Reset while holding '5'
    kmask[4*1+1] = 1'b1;
    wait_cyc(60);
    chk("held5_rises",  n_rise, 32'd5);
    chk("held5_number", number, 32'd5);
    chk("held5_down",   {31'd0, pressed[0]}, 32'd1);
    rst = 1'b1;
    kmask[4*1+1] = 1'b0;
    wait_cyc(1);
    rst = 1'b0;
    chk("rst_held_col_n",   {28'd0, col_n},   32'hE);
    chk("rst_held_pressed", {30'd0, pressed}, 32'd0);
    chk("rst_held_key",     {28'd0, key},     32'd0);
    wait_cyc(40);
    chk("rst_held_no_strobe", n_rise, 32'd5);

    // Hold '0' (row 3, col 1) for 18 samples after acceptance
    kmask[4*3+1] = 1'b1;
    wait_strobe(6);
    wait_cyc(72);
    kmask[4*3+1] = 1'b0;
    wait_cyc(40);
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("hold0_rises", n_rise, 32'd9);
    chk("hold0_width", n_hi,   32'd9);
`else
    chk("hold0_rises", n_rise, 32'd6);
    chk("hold0_width", n_hi,   32'd6);
`endif
    chk("hold0_number", number, 32'd0);
    chk("hold0_strobe_number", strobe_num, 32'd0);
    chk("hold0_release", {31'd0, pressed[0]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
